// File: rtl/load_store_unit_if.sv
// Interfaces for load_store_unit.
//
// load_store_unit_req_if : request/response channel between a core and the unit.
//    master = requester (core), slave = load_store_unit.
//    req_valid/req_ready handshake, req_we, req_func3, req_addr, req_wdata in;
//    rsp_valid pulse with rsp_rdata and rsp_err back.
//
// load_store_unit_bus_if : single-outstanding memory bus.
//    master = load_store_unit, slave = memory.
//    busReq/busWe/busAddr/busBe/busWData out; busRData/busAck back.

interface load_store_unit_req_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_func3;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              rsp_valid;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_func3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_func3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

interface load_store_unit_bus_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              busReq;
   logic              busWe;
   logic [ADDR_W-1:0] busAddr;
   logic [XLEN/8-1:0] busBe;
   logic [XLEN-1:0]   busWData;
   logic [XLEN-1:0]   busRData;
   logic              busAck;

   modport master (
      output busReq, busWe, busAddr, busBe, busWData,
      input  busRData, busAck
   );

   modport slave (
      input  busReq, busWe, busAddr, busBe, busWData,
      output busRData, busAck
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: takes one RISC-V style load/store at a time, checks width
// code and alignment, runs a single bus access with a timeout, and returns the
// lane-extracted, sign/zero-extended load data as a one-cycle response.
//
// Ports:
//    clk    in  rising-edge clock
//    reset  in  synchronous, active-high reset
//    req    load_store_unit_req_if.slave  (request in, response out)
//    bus    load_store_unit_bus_if.master (memory access out, ack/data in)
//
// Parameters: XLEN (32 or 64), ADDR_W byte-address width (>= 3),
// TIMEOUT bus cycles without busAck before an error (0 = never).
//
// state  | meaning
// S_IDLE | req_ready=1, waiting for a request
// S_BUS  | busReq=1, waiting for busAck or timeout
// S_RESP | rsp_valid=1 for one cycle, then back to idle

module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic                   clk,
   input logic                   reset,
   load_store_unit_req_if.slave  req,
   load_store_unit_bus_if.master bus
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state_q;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              err_q;
   logic [XLEN-1:0]   rdata_q;

   logic              legal_f3;
   logic              misalign;
   logic              req_bad;
   logic              in_bus;
   logic              tmo_hit;
   logic [OFF_W-1:0]  off_q;
   logic [NB-1:0]     be_base;
   logic [XLEN-1:0]   size_mask;
   logic [XLEN-1:0]   rshift;
   logic [XLEN-1:0]   load_ext;

   // Request legality, evaluated on the live request fields in IDLE.
   always_comb begin
      legal_f3 = 1'b0;
      case (req.req_func3)
         3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
         3'b100, 3'b101:         legal_f3 = !req.req_we;
         3'b011:                 legal_f3 = (XLEN == 64);
         3'b110:                 legal_f3 = (XLEN == 64) && !req.req_we;
         default:                legal_f3 = 1'b0;
      endcase

      misalign = 1'b0;
      case (req.req_func3[1:0])
         2'b01:   misalign = req.req_addr[0];
         2'b10:   misalign = |req.req_addr[1:0];
         2'b11:   misalign = |req.req_addr[2:0];
         default: misalign = 1'b0;
      endcase
   end

   assign req_bad = !legal_f3 || misalign;
   assign in_bus  = (state_q == S_BUS);
   assign off_q   = addr_q[OFF_W-1:0];

   // The counter holds the number of completed ack-less BUS cycles, so the
   // cycle that would bring it to TIMEOUT is the one that times out.
   assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   // Byte-enable and data-lane shaping from the latched request.
   always_comb begin
      be_base   = '1;
      size_mask = '1;
      case (f3_q[1:0])
         2'b00: begin
            be_base   = NB'(1);
            size_mask = XLEN'(8'hFF);
         end
         2'b01: begin
            be_base   = NB'(3);
            size_mask = XLEN'(16'hFFFF);
         end
         2'b10: begin
            be_base   = NB'(15);
            size_mask = XLEN'(32'hFFFF_FFFF);
         end
         default: begin
            be_base   = '1;
            size_mask = '1;
         end
      endcase
   end

   // Load lane extraction: move the addressed lane down to bit 0, then extend.
   assign rshift = bus.busRData >> {off_q, 3'b000};

   always_comb begin
      load_ext = rshift;
      case (f3_q)
         3'b000:  load_ext = XLEN'($signed(rshift[7:0]));
         3'b001:  load_ext = XLEN'($signed(rshift[15:0]));
         3'b010:  load_ext = XLEN'($signed(rshift[31:0]));
         3'b100:  load_ext = XLEN'(rshift[7:0]);
         3'b101:  load_ext = XLEN'(rshift[15:0]);
         3'b110:  load_ext = XLEN'(rshift[31:0]);
         default: load_ext = rshift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req.req_valid) begin
                  we_q    <= req.req_we;
                  f3_q    <= req.req_func3;
                  addr_q  <= req.req_addr;
                  wdata_q <= req.req_wdata;
                  cnt_q   <= '0;
                  rdata_q <= '0;
                  if (req_bad) begin
                     err_q   <= 1'b1;
                     state_q <= S_RESP;
                  end else begin
                     err_q   <= 1'b0;
                     state_q <= S_BUS;
                  end
               end
            end
            S_BUS: begin
               // busAck takes priority over a timeout in the same cycle.
               if (bus.busAck) begin
                  rdata_q <= we_q ? '0 : load_ext;
                  state_q <= S_RESP;
               end else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RESP: begin
               err_q   <= 1'b0;
               rdata_q <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req.req_ready = (state_q == S_IDLE);
   assign req.rsp_valid = (state_q == S_RESP);
   assign req.rsp_err   = (state_q == S_RESP) && err_q;
   assign req.rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;

   // Bus outputs are forced to zero outside BUS so nothing stale leaks out.
   assign bus.busReq   = in_bus;
   assign bus.busWe    = in_bus && we_q;
   assign bus.busAddr  = in_bus ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign bus.busBe    = (in_bus && we_q) ? (be_base << off_q) : '0;
   assign bus.busWData = (in_bus && we_q) ? ((wdata_q & size_mask) << {off_q, 3'b000}) : '0;

endmodule
